alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between NREQ requesters (e.g. EX-stage issue, address-gen, debug unit).
- Round-robin grant with a valid/ready handshake on both request and response sides.
- Each operation runs a fixed 3-state sequence: IDLE, EXEC, RESP.
- Drives the ALU's sel/a/b inputs from registered operands and returns the registered result/zero to the owning requester.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ) (min 1), width of the grant index.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has an op pending
- req_sel  in  NREQ x alu_sel_e  op per requester (AND/OR/ADD/SUB)
- req_a  in  NREQ x 32  operand a per requester
- req_b  in  NREQ x 32  operand b per requester
- req_ready  out  NREQ  one-hot grant; op accepted when req_valid[i] & req_ready[i]
- rsp_valid  out  NREQ  one-hot; result for requester i is available
- rsp_result  out  32  result, shared bus, valid where rsp_valid set
- rsp_zero  out  1  zero flag of rsp_result
- rsp_ready  in  NREQ  requester i consumes its response
- alu_sel  out  alu_sel_e  to ALU sel
- alu_a  out  32  to ALU a
- alu_b  out  32  to ALU b
- alu_result  in  32  from ALU result
- alu_zero  in  1  from ALU zero
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0, owner=0, op registers=0, result/zero registers=0. req_ready, rsp_valid and busy deassert in the cycle after the reset edge. Reset mid-EXEC or mid-RESP aborts the op; no response is ever issued for it.
- Arbitration (IDLE only):
  - Winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[winner]=1 combinationally; all other req_ready=0.
  - req_ready is all zero outside IDLE and when no req_valid is set.
- IDLE -> EXEC on handshake: latch sel/a/b of the winner into op registers; owner<=winner.
- EXEC:
  - alu_sel/alu_a/alu_b driven from op registers; held stable in every state (values after reset are 0 / ADD-encoding 0 default).
  - Capture alu_result and alu_zero into result registers; go to RESP. Exactly one cycle.
- RESP:
  - rsp_valid[owner]=1.
  - rsp_result and rsp_zero come from registers and are stable until the handshake.
  - On rsp_ready[owner]: go to IDLE, rr_ptr <= (owner+1) mod NREQ.
  - rsp_ready of non-owners is ignored.
- Latency: request accept edge to rsp_valid is 2 cycles. Minimum issue interval is 3 cycles (accept, EXEC, RESP with immediate ready).
- No back-to-back bypass. A request held valid during EXEC/RESP stays pending and is not dropped. Requesters must hold req_* stable while valid and not ready.
- Fairness: a requester continuously valid is granted within NREQ ops.
- Zero flag is the ALU's own flag, passed through unmodified. Default-encoded sel yields result 0, zero=1.
- rr_ptr wraps NREQ-1 -> 0. For NREQ not a power of two, rr_ptr never exceeds NREQ-1.

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - Adds output port op_count, NREQ x 16.
  - Per-requester counter of completed ops, incremented on the RESP handshake.
  - Saturates at 16'hFFFF; cleared by rst.
- Not defined: port and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: rst high 2 cycles, no req_valid -> req_ready=0, rsp_valid=0, busy=0, alu_a=alu_b=0.
- Single op: req 0 ADD a=32'h7FFF_FFFF, b=1, rsp_ready tied 1 -> rsp_valid[0] 2 cycles after accept, rsp_result=32'h8000_0000, rsp_zero=0, busy low on the following cycle.
- Zero flag: req 1 SUB a=b=32'h1234_5678 -> rsp_result=0, rsp_zero=1, rsp_valid[1] only.
- Round robin: req 0 and req 1 both valid continuously with NREQ=2 -> grants alternate 0,1,0,1 over 4 ops. With NREQ=3 and all valid from reset -> grant order 0,1,2,0.
- Response backpressure: req 0 OR a=32'hF0F0_0000, b=32'h0000_0F0F, rsp_ready low 5 cycles -> rsp_valid[0] and rsp_result=32'hF0F0_0F0F held; req 1 valid meanwhile gets no req_ready until 1 cycle after rsp_ready.
- Reset mid-op: assert rst during EXEC of an AND op -> no rsp_valid ever for that op, rr_ptr=0. With ALU_ARB_STATS_EN, op_count all 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU signal bundle for the shared-ALU arbiter; sel encoding 0 ADD, 1 SUB, 2 AND, 3 OR.
// op_count (per-requester completed-op counters) exists only when ALU_ARB_STATS_EN is defined.
interface alu_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0][1:0]   req_sel;
    logic [NREQ-1:0][31:0]  req_a;
    logic [NREQ-1:0][31:0]  req_b;
    logic [NREQ-1:0]        req_ready;

    logic [NREQ-1:0]        rsp_valid;
    logic [31:0]            rsp_result;
    logic                   rsp_zero;
    logic [NREQ-1:0]        rsp_ready;

    logic [1:0]             alu_sel;
    logic [31:0]            alu_a;
    logic [31:0]            alu_b;
    logic [31:0]            alu_result;
    logic                   alu_zero;

    logic                   busy;
`ifdef ALU_ARB_STATS_EN
    logic [NREQ-1:0][15:0]  op_count;
`endif

`ifdef ALU_ARB_STATS_EN
    modport slave (
        input  req_valid, req_sel, req_a, req_b, rsp_ready, alu_result, alu_zero,
        output req_ready, rsp_valid, rsp_result, rsp_zero, alu_sel, alu_a, alu_b, busy, op_count
    );
    modport master (
        output req_valid, req_sel, req_a, req_b, rsp_ready, alu_result, alu_zero,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, alu_sel, alu_a, alu_b, busy, op_count
    );
`else
    modport slave (
        input  req_valid, req_sel, req_a, req_b, rsp_ready, alu_result, alu_zero,
        output req_ready, rsp_valid, rsp_result, rsp_zero, alu_sel, alu_a, alu_b, busy
    );
    modport master (
        output req_valid, req_sel, req_a, req_b, rsp_ready, alu_result, alu_zero,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, alu_sel, alu_a, alu_b, busy
    );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one 32-bit ALU among NREQ requesters; accept -> rsp_valid in 2 cycles, one op in flight.
// Response held until rsp_ready[owner]; new requests wait in IDLE. ALU_ARB_STATS_EN adds saturating op_count.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        SEL_ADD = 2'd0,
        SEL_SUB = 2'd1,
        SEL_AND = 2'd2,
        SEL_OR  = 2'd3
    } alu_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    alu_sel_e        op_sel_q, op_sel_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic [31:0]     res_q, res_d;
    logic            zero_q, zero_d;

    logic [IDW-1:0]  winner;
    logic            win_vld;
    logic [IDW:0]    idx;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] rsp_valid;
    logic            rsp_hs;

    // Scan from rr_ptr upward with wrap; idx is one bit wider so ptr+k never overflows.
    always_comb begin
        win_vld = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!win_vld && bus.req_valid[idx[IDW-1:0]]) begin
                win_vld = 1'b1;
                winner  = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        op_sel_d  = op_sel_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_d     = res_q;
        zero_d    = zero_q;
        req_ready = '0;
        rsp_valid = '0;
        rsp_hs    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    req_ready[winner] = 1'b1;
                    state_d  = S_EXEC;
                    owner_d  = winner;
                    op_sel_d = alu_sel_e'(bus.req_sel[winner]);
                    op_a_d   = bus.req_a[winner];
                    op_b_d   = bus.req_b[winner];
                end
            end
            S_EXEC: begin
                res_d   = bus.alu_result;
                zero_d  = bus.alu_zero;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (bus.rsp_ready[owner_q]) begin
                    rsp_hs   = 1'b1;
                    state_d  = S_IDLE;
                    rr_ptr_d = (owner_q == IDW'(NREQ-1)) ? '0 : owner_q + IDW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            op_sel_q <= SEL_ADD;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            op_sel_q <= op_sel_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.alu_sel    = op_sel_q;
    assign bus.alu_a      = op_a_q;
    assign bus.alu_b      = op_b_q;
    assign bus.busy       = (state_q != S_IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [NREQ-1:0][15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rsp_hs && (cnt_q[owner_q] != 16'hFFFF)) begin
            cnt_q[owner_q] <= cnt_q[owner_q] + 16'd1;
        end
    end

    assign bus.op_count = cnt_q;
`endif
endmodule
